ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Shared screen/work RAM arbiter: the CPU owns the RAM by default and the video renderer takes it in whole-line bursts.
// Optional stall statistics are compiled in with the RAM_ARBITER_STATS_EN macro.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_din,
    output logic                  cpu_rdy,
    output logic [DATA_WIDTH-1:0] cpu_dout,
    output logic                  cpu_dvalid,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_grant,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  vid_valid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef RAM_ARBITER_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [15:0]           stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_CPU,
        ST_HANDOFF,
        ST_VIDEO,
        ST_RETURN
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_cpu_dvalid;
    logic   r_vid_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_CPU;
            r_cpu_dvalid <= 1'b0;
            r_vid_valid  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cpu_dvalid <= (r_state == ST_CPU) && cpu_req && !cpu_we;
            r_vid_valid  <= (r_state == ST_VIDEO);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next    = r_state;
        cpu_rdy   = 1'b0;
        vid_grant = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = cpu_addr;
        unique case (r_state)
            ST_CPU: begin
                cpu_rdy = 1'b1;
                // NOTE: reset gates the write strobe so a request during reset never reaches the RAM.
                ram_we  = reset && cpu_req && cpu_we;
                if (vid_req) w_next = ST_HANDOFF;
            end
            ST_HANDOFF: begin
                ram_addr = vid_addr;
                w_next   = vid_req ? ST_VIDEO : ST_RETURN;
            end
            ST_VIDEO: begin
                vid_grant = 1'b1;
                ram_addr  = vid_addr;
                if (!vid_req) w_next = ST_RETURN;
            end
            ST_RETURN: begin
                w_next = ST_CPU;
            end
            default: begin
                w_next = ST_CPU;
            end
        endcase
    end

    // Both masters see the same registered RAM output; the valid strobes say whose it is.
    assign ram_din    = cpu_din;
    assign cpu_dout   = ram_dout;
    assign vid_data   = ram_dout;
    assign cpu_dvalid = r_cpu_dvalid;
    assign vid_valid  = r_vid_valid;

`ifdef RAM_ARBITER_STATS_EN
    logic        w_stall;
    logic [15:0] r_stall_count;

    assign w_stall = cpu_req && !cpu_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_count <= 16'd0;
        end else if (stats_clr) begin
            r_stall_count <= 16'd0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
